// File: rtl/sseg_scan_driver_if.sv
// Bundle between the display controller and the scan driver.
//   data_in     : 16-bit value to show ([15:12] = leftmost digit)
//   load        : capture data_in into the held value this cycle
//   en          : display enable; 0 keeps every anode off
//   blank_lz    : suppress leading zeros on digits 3..1
//   nibble      : 4-bit value for the digit in the current slot
//   an          : active-low anode drive, at most one bit low
//   digit_blank : current slot is dark; segments must be forced off
// master = controller side, slave = scan driver side.
interface sseg_if;
  logic [15:0] data_in;
  logic        load;
  logic        en;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        digit_blank;

  modport master (
    output data_in, load, en, blank_lz,
    input  nibble, an, digit_blank
  );

  modport slave (
    input  data_in, load, en, blank_lz,
    output nibble, an, digit_blank
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// A free-running divider produces one tick every REFRESH_DIV cycles; each tick
// advances the digit pointer and registers the anode/nibble/blank outputs for
// the new slot, so outputs only ever change on ticks.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sseg_if slave modport (data_in, load, en, blank_lz in;
//           nibble, an, digit_blank out)
module sseg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic   clk,
  input  logic   rst_n,
  sseg_if.slave  bus
);

  localparam int            CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [15:0]   held;
  logic [1:0]    ptr;
  logic [3:0]    an_q;
  logic [3:0]    nibble_q;
  logic          blank_q;

  logic          tick;
  logic [1:0]    ptr_nxt;
  logic [3:0]    nib_nxt;
  logic          lz_nxt;
  logic          blank_nxt;

  // Next-slot decode. Uses the held value as it stands before this edge, so a
  // load coinciding with a tick is only seen from the following tick.
  always_comb begin
    tick    = (div_cnt == DIV_LAST);
    ptr_nxt = ptr + 2'd1;
    nib_nxt = 4'h0;
    lz_nxt  = 1'b0;
    case (ptr_nxt)
      2'd0: begin
        nib_nxt = held[3:0];
        lz_nxt  = 1'b0;                 // digit 0 always shows, even for zero
      end
      2'd1: begin
        nib_nxt = held[7:4];
        lz_nxt  = (held[15:4] == 12'h000);
      end
      2'd2: begin
        nib_nxt = held[11:8];
        lz_nxt  = (held[15:8] == 8'h00);
      end
      default: begin
        nib_nxt = held[15:12];
        lz_nxt  = (held[15:12] == 4'h0);
      end
    endcase
    blank_nxt = !bus.en || (bus.blank_lz && lz_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held     <= 16'h0000;
      div_cnt  <= '0;
      ptr      <= 2'd3;                 // first tick wraps to digit 0
      an_q     <= 4'b1111;
      nibble_q <= 4'h0;
      blank_q  <= 1'b1;
    end else begin
      if (bus.load) begin
        held <= bus.data_in;
      end
      if (tick) begin
        div_cnt <= '0;
        ptr     <= ptr_nxt;
        if (blank_nxt) begin
          an_q     <= 4'b1111;
          nibble_q <= 4'h0;
          blank_q  <= 1'b1;
        end else begin
          an_q     <= ~(4'b0001 << ptr_nxt);
          nibble_q <= nib_nxt;
          blank_q  <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.nibble      = nibble_q;
  assign bus.digit_blank = blank_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with REFRESH_DIV = 4.
module tb_sseg_scan_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sseg_if bus ();

  sseg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two-cycle reset; returns 1 ns after the second reset edge with rst_n high.
  task automatic do_reset();
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.data_in  = 16'h0000;
    step(2);
    rst_n = 1'b1;
  endtask

  // Reset, then load a value on the first edge and run up to the first tick
  // (4th edge after release), which shows digit 0.
  task automatic reset_load_to_first_tick(input logic [15:0] val);
    do_reset();
    bus.load    = 1'b1;
    bus.data_in = val;
    step(1);
    bus.load = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    bus.en       = 1'b1;
    bus.blank_lz = 1'b0;
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      obs = {bus.an, bus.nibble, bus.digit_blank};
      checks++;
      if (obs !== {4'b1111, 4'h0, 1'b1}) begin
        errors++;
        $display("FAIL reset_hold edge%0d: got an=%b nib=%h blk=%b, want an=1111 nib=0 blk=1",
                 e - 1, bus.an, bus.nibble, bus.digit_blank);
      end
      step(1);
    end
    // after the 3rd edge: still dark
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1111, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_edge3: got an=%b nib=%h blk=%b, want an=1111 nib=0 blk=1",
               bus.an, bus.nibble, bus.digit_blank);
    end
    step(1);
    // 4th edge: first tick, digit 0 of 0x0000
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1110, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_tick: got an=%b nib=%h blk=%b, want an=1110 nib=0 blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exp_nib [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
    logic [8:0] obs;
    int d;
    bus.en       = 1'b1;
    bus.blank_lz = 1'b0;
    reset_load_to_first_tick(16'h1A2F);
    for (int c = 0; c < 20; c++) begin
      d   = (c / 4) % 4;
      obs = {bus.an, bus.nibble, bus.digit_blank};
      checks++;
      if (obs !== {exp_an[d], exp_nib[d], 1'b0}) begin
        errors++;
        $display("FAIL scan cyc%0d: got an=%b nib=%h blk=%b, want an=%b nib=%h blk=0",
                 c, bus.an, bus.nibble, bus.digit_blank, exp_an[d], exp_nib[d]);
      end
      step(1);
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0800};
    // per value, per digit 0..3: {an, nibble, blank}
    logic [8:0]  exp  [3][4] = '{
      '{{4'b1110, 4'h5, 1'b0}, {4'b1111, 4'h0, 1'b1}, {4'b1111, 4'h0, 1'b1}, {4'b1111, 4'h0, 1'b1}},
      '{{4'b1110, 4'h0, 1'b0}, {4'b1111, 4'h0, 1'b1}, {4'b1111, 4'h0, 1'b1}, {4'b1111, 4'h0, 1'b1}},
      '{{4'b1110, 4'h0, 1'b0}, {4'b1101, 4'h0, 1'b0}, {4'b1011, 4'h8, 1'b0}, {4'b1111, 4'h0, 1'b1}}
    };
    logic [8:0] obs;
    bus.en       = 1'b1;
    bus.blank_lz = 1'b1;
    for (int v = 0; v < 3; v++) begin
      reset_load_to_first_tick(vals[v]);
      for (int d = 0; d < 4; d++) begin
        obs = {bus.an, bus.nibble, bus.digit_blank};
        checks++;
        if (obs !== exp[v][d]) begin
          errors++;
          $display("FAIL lz val=%h dig%0d: got an=%b nib=%h blk=%b, want an=%b nib=%h blk=%b",
                   vals[v], d, bus.an, bus.nibble, bus.digit_blank,
                   exp[v][d][8:5], exp[v][d][4:1], exp[v][d][0]);
        end
        step(4);
      end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_load_on_tick();
    logic [8:0] obs;
    bus.en       = 1'b1;
    bus.blank_lz = 1'b0;
    reset_load_to_first_tick(16'h1234);
    step(3);
    // next edge is a tick; load rides on it
    bus.load    = 1'b1;
    bus.data_in = 16'hBEEF;
    step(1);
    bus.load = 1'b0;
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1101, 4'h3, 1'b0}) begin
      errors++;
      $display("FAIL load_tick_old: got an=%b nib=%h blk=%b, want an=1101 nib=3 blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
    step(3);
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1101, 4'h3, 1'b0}) begin
      errors++;
      $display("FAIL load_tick_midslot: got an=%b nib=%h blk=%b, want an=1101 nib=3 blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
    step(1);
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1011, 4'hE, 1'b0}) begin
      errors++;
      $display("FAIL load_tick_new2: got an=%b nib=%h blk=%b, want an=1011 nib=e blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
    step(4);
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b0111, 4'hB, 1'b0}) begin
      errors++;
      $display("FAIL load_tick_new3: got an=%b nib=%h blk=%b, want an=0111 nib=b blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
  endtask

  task automatic test_enable_off();
    logic [8:0] obs;
    bus.blank_lz = 1'b0;
    bus.en       = 1'b0;
    reset_load_to_first_tick(16'h1A2F);
    for (int k = 0; k < 8; k++) begin
      obs = {bus.an, bus.nibble, bus.digit_blank};
      checks++;
      if (obs !== {4'b1111, 4'h0, 1'b1}) begin
        errors++;
        $display("FAIL en_off slot%0d: got an=%b nib=%h blk=%b, want an=1111 nib=0 blk=1",
                 k, bus.an, bus.nibble, bus.digit_blank);
      end
      step(3);
      if (k == 7) bus.en = 1'b1;
      step(1);
    end
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1110, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL en_resume_d0: got an=%b nib=%h blk=%b, want an=1110 nib=f blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
    step(4);
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1101, 4'h2, 1'b0}) begin
      errors++;
      $display("FAIL en_resume_d1: got an=%b nib=%h blk=%b, want an=1101 nib=2 blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
  endtask

  task automatic test_mid_reset();
    logic [8:0] obs;
    bus.en       = 1'b1;
    bus.blank_lz = 1'b0;
    reset_load_to_first_tick(16'h1A2F);
    step(8);
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1011, 4'hA, 1'b0}) begin
      errors++;
      $display("FAIL midrst_pre: got an=%b nib=%h blk=%b, want an=1011 nib=a blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1111, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_edge: got an=%b nib=%h blk=%b, want an=1111 nib=0 blk=1",
               bus.an, bus.nibble, bus.digit_blank);
    end
    step(3);
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1111, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_no_partial: got an=%b nib=%h blk=%b, want an=1111 nib=0 blk=1",
               bus.an, bus.nibble, bus.digit_blank);
    end
    step(1);
    obs = {bus.an, bus.nibble, bus.digit_blank};
    checks++;
    if (obs !== {4'b1110, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_first_tick: got an=%b nib=%h blk=%b, want an=1110 nib=0 blk=0",
               bus.an, bus.nibble, bus.digit_blank);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.data_in  = 16'h0000;
    bus.en       = 1'b1;
    bus.blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_leading_zero();
    test_load_on_tick();
    test_enable_off();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It holds a 16-bit display value and steps through the digits at a divided refresh rate, driving one active-low anode at a time. For each digit it presents the matching 4-bit nibble to the downstream binary-to-seven-segment decoder, plus a blank flag the top level uses to force that decoder's segments off. Optional leading-zero blanking and a global display enable are included.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit, 250 Hz frame); legal range >= 2
Counter width, derived, $clog2(REFRESH_DIV); not overridable

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
data_in  input  16  value to display; [15:12] = digit 3 (leftmost), [3:0] = digit 0
load  input  1  capture data_in into the held value this cycle
en  input  1  display enable; 0 = all anodes off
blank_lz  input  1  1 = suppress leading zeros on digits 3..1
nibble  output  4  nibble for the current digit, to the decoder's binary input
an  output  4  anode drive, active-low, at most one bit low
digit_blank  output  1  1 = current slot dark; the top level forces seg to 7'b1111111

Behaviour:
- Reset applies when rst_n = 0 at a rising clk edge. It sets:
  - held value = 16'h0000
  - div_cnt = 0
  - digit pointer = 3
  - an = 4'b1111, nibble = 4'h0, digit_blank = 1
- Divider:
  - div_cnt increments every cycle.
  - When div_cnt == REFRESH_DIV-1, div_cnt wraps to 0 and a one-cycle internal tick fires.
- First tick after reset release occurs on the REFRESH_DIV-th edge. The pointer wraps 3 -> 0, so digit 0 is displayed first.
- On each tick, registered and together:
  - pointer <= (pointer+1) mod 4
  - nibble <= held[4*p+3 : 4*p] for the new pointer p
  - an <= all ones with bit p cleared, unless the slot is blank
- Outputs change only on ticks. They are stable for exactly REFRESH_DIV cycles per slot.
- Load:
  - load = 1 captures data_in into the held value on that edge.
  - The new value first appears at the next tick, so there is no mid-slot change.
  - load on the same edge as a tick: that tick uses the pre-load held value; the new value appears from the following tick.
  - Back-to-back loads: the last one wins.
- Blank decision, evaluated at tick time for the new slot p:
  - en = 0 -> slot blank.
  - blank_lz = 1 and p >= 1 and held nibbles p..3 all zero -> slot blank.
  - Digit 0 is never leading-zero blanked, so 0x0000 shows a single "0".
  - Blank slot: an = 4'b1111, digit_blank = 1, nibble = 4'h0.
  - Non-blank slot: digit_blank = 0.
- en and blank_lz are sampled only at ticks. A change takes effect from the next slot.
- Scanning (pointer and divider) continues while en = 0.
- Reset mid-slot: all state returns to reset values on that edge. The divider restarts from 0 with no partial slot.
- nibble width is 4 bits. Values 10-15 pass through unchanged; the decoder shows them as A-F.

Test Plan:
1. REFRESH_DIV=4. Hold rst_n=0 for 2 cycles, then release -> an=1111, digit_blank=1, nibble=0 until the 4th edge after release.
2. REFRESH_DIV=4, en=1, blank_lz=0, load 16'h1A2F once, then run 20 cycles -> slots in order:
   - (an=1110, nibble=F)
   - (1101, 2)
   - (1011, A)
   - (0111, 1)
   - then repeat
   - each slot lasts exactly 4 cycles; digit_blank=0 throughout.
3. blank_lz=1 with various loads:
   - load 16'h0005 -> digit0 an=1110, nibble=5; digits 1-3 an=1111, digit_blank=1.
   - load 16'h0000 -> only digit0 lit, nibble=0.
   - load 16'h0800 -> digit3 blank; digit1 shows 0 with an=1101 (not blanked).
4. Assert load with data_in=16'hBEEF on the same edge as a tick, with old value 16'h1234 -> that slot shows the old nibble. The following slot shows the BEEF nibble for its digit.
5. en=0 for 2 full frames -> an=1111 and digit_blank=1 in every slot, pointer still advances. Set en=1 -> the next slot lights the correct digit in sequence.
6. Drop rst_n=0 for 1 cycle mid-slot while digit 2 is showing 16'h1A2F -> an=1111 and held value=0 after that edge. After release, the next 4 edges produce the first tick: digit0, nibble=0.
